// File: rtl/shift_register_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
//   Shared constants for the shift_register block.
//   DIR_RIGHT / DIR_LEFT : encodings of the shift_left port value.
//   WIDTH_DEFAULT        : default register length in bits.
// ---------------------------------------------------------------------------
package shift_pkg;

    localparam logic DIR_RIGHT     = 1'b0;   // shift toward LSB
    localparam logic DIR_LEFT      = 1'b1;   // shift toward MSB
    localparam int   WIDTH_DEFAULT = 8;

endpackage : shift_pkg

// File: rtl/shift_register_rst_sync.sv
// ---------------------------------------------------------------------------
// rst_sync
//   Two-flop reset synchroniser. Reset assertion passes through at once,
//   independent of clk. Reset release reaches the output on the second
//   rising clk edge after the input goes high.
// Ports
//   clk         : input   rising-edge clock
//   rst_n       : input   asynchronous active-low reset
//   rst_sync_n  : output  active-low reset; asserts asynchronously,
//                         releases synchronously to clk
// ---------------------------------------------------------------------------
module rst_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic meta_n;

    // NOTE: sequential state uses non-blocking assignments, so both flops
    // sample their pre-edge values and the release takes two full edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_n     <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            meta_n     <= 1'b1;
            rst_sync_n <= meta_n;
        end
    end

endmodule : rst_sync

// File: rtl/shift_register.sv
// ---------------------------------------------------------------------------
// shift_register
//   Serial-in / parallel-out shift register with run-time direction select.
//   Shifts one bit on every rising clk edge. There is no enable, so the
//   register never holds its value.
// Parameters
//   WIDTH       : register length in bits, 2..64
// Ports
//   clk         : input   rising-edge clock
//   reset       : input   asynchronous active-low reset (asserted when 0)
//   shift_in    : input   serial data bit entering the register
//   shift_left  : input   1 = shift toward MSB, 0 = shift toward LSB
//   q           : output  current register contents
// ---------------------------------------------------------------------------
module shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_in,
    input  logic             shift_left,
    output logic [WIDTH-1:0] q
);

    // Clears the register the moment reset falls; releases it on the second
    // clk edge after reset rises, so the first shift lands on the third edge.
    logic clr_n;

    rst_sync u_rst_sync (
        .clk        (clk),
        .rst_n      (reset),
        .rst_sync_n (clr_n)
    );

    logic [WIDTH-1:0] q_next;

    always_comb begin
        q_next = q;
        if (shift_left == DIR_LEFT) begin
            q_next = {q[WIDTH-2:0], shift_in};   // MSB falls off
        end else begin
            q_next = {shift_in, q[WIDTH-1:1]};   // LSB falls off
        end
    end

    // NOTE: every register bit is cleared by reset; there is no storage
    // here that can be left unreset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

`ifdef ASSERT_ON
    // Register stays clear while the external reset is held low.
    property p_clear_in_reset;
        @(posedge clk) !reset |-> (q == '0);
    endproperty
    a_clear_in_reset : assert property (p_clear_in_reset);

    // After a left shift, the sampled serial bit sits in the LSB.
    property p_left_lsb;
        @(posedge clk) disable iff (!reset)
            ($past(clr_n) && $past(shift_left) == DIR_LEFT) |-> (q[0] == $past(shift_in));
    endproperty
    a_left_lsb : assert property (p_left_lsb);
`endif

endmodule : shift_register

// File: tb/tb_shift_register.sv
// ---------------------------------------------------------------------------
// tb_shift_register
//   Directed bench for shift_register at WIDTH = 8. Inputs change 1 ns after
//   a rising edge; q is checked 1 ns after the edge it should reflect.
// ---------------------------------------------------------------------------
module tb_shift_register;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             shift_in;
    logic             shift_left;
    logic [WIDTH-1:0] q;

    int total  = 0;
    int passed = 0;

    shift_register #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .shift_in   (shift_in),
        .shift_left (shift_left),
        .q          (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] exp);
        total++;
        assert (q === exp) passed++;
        else $error("FAIL %s: q=%h expected %h", tag, q, exp);
    endtask

    // Drive one edge's inputs, take the edge, settle past it.
    task automatic step(input logic sl, input logic si);
        shift_left = sl;
        shift_in   = si;
        @(posedge clk);
        #1;
    endtask

    // Release reset, take the two synchroniser edges (register must stay
    // clear even though a 1 is being shifted in), leave q at 00.
    task automatic release_reset(input string tag);
        reset = 1'b1;
        step(1'b1, 1'b1);
        check({tag, "_rel_edge1"}, 8'h00);
        step(1'b1, 1'b1);
        check({tag, "_rel_edge2"}, 8'h00);
    endtask

    logic [WIDTH-1:0] walk_exp;

    initial begin
        reset      = 1'b0;
        shift_in   = 1'b0;
        shift_left = 1'b1;

        // 1: reset from power-up, held for two edges
        #2;
        check("reset_async", 8'h00);
        step(1'b1, 1'b1);
        check("reset_hold1", 8'h00);
        step(1'b1, 1'b1);
        check("reset_hold2", 8'h00);
        release_reset("r1");

        // 2: left shift, 1 then 0
        step(1'b1, 1'b1); check("left_a", 8'h01);
        step(1'b1, 1'b0); check("left_b", 8'h02);

        // 3: right shift, 1 then 0
        step(1'b0, 1'b1); check("right_a", 8'h81);
        step(1'b0, 1'b0); check("right_b", 8'h40);

        // 4: left pattern 1,1,0
        step(1'b1, 1'b1); check("lpat_a", 8'h81);
        step(1'b1, 1'b1); check("lpat_b", 8'h03);
        step(1'b1, 1'b0); check("lpat_c", 8'h06);

        // 5: right pattern 1,0,1
        step(1'b0, 1'b1); check("rpat_a", 8'h83);
        step(1'b0, 1'b0); check("rpat_b", 8'h41);
        step(1'b0, 1'b1); check("rpat_c", 8'hA0);

        // mid-cycle reset clears q without a clock edge
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_async", 8'h00);
        @(posedge clk); #1;
        check("mid_reset_hold", 8'h00);
        release_reset("r2");
        step(1'b1, 1'b1); check("post_release_first", 8'h01);

        // 6: walk ones in from the right, then zeros in from the left
        reset = 1'b0;
        #1;
        check("walk_reset", 8'h00);
        release_reset("r3");
        walk_exp = 8'h00;
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b1, 1'b1);
            walk_exp = {walk_exp[WIDTH-2:0], 1'b1};
            check($sformatf("walk_left_%0d", i), walk_exp);
        end
        check("walk_full", 8'hFF);
        // one more left shift of 0: MSB must fall off, not wrap
        step(1'b1, 1'b0); check("left_drop_msb", 8'hFE);
        step(1'b0, 1'b1); check("right_refill", 8'hFF);
        walk_exp = 8'hFF;
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b0, 1'b0);
            walk_exp = {1'b0, walk_exp[WIDTH-1:1]};
            check($sformatf("walk_right_%0d", i), walk_exp);
        end
        check("walk_empty", 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_shift_register
